byte_mem_master: RTL and testbench



---
 rtl/byte_mem_master_pkg.sv | 24 ++
 rtl/byte_mem_master_if.sv | 39 +++
 rtl/byte_mem_master_load_extend.sv | 24 ++
 rtl/byte_mem_master.sv | 159 +++++++++++++++
 tb/tb_byte_mem_master.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_mem_master_pkg.sv
// Shared definitions for the byte-wide memory access path: size encodings,
// the access FSM state type and the bytes-per-access helper.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of byte cycles for a request size; size 3 is handled as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_mem_master_if.sv
// Request/response and RAM-side signals of byte_mem_master.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the response is a one-cycle resp_valid pulse with no backpressure.
interface byte_mem_master_if #(
    parameter int XLEN = 32,
    parameter int AW   = 10
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            mem_write_en;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic [7:0]      mem_rdata;

    // Access unit side.
    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_write_en, mem_addr, mem_wdata
    );

    // Requester / RAM side.
    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_write_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/byte_mem_master_load_extend.sv
// Combinational load data extension: picks byte/half/word from an assembled
// little-endian buffer and sign- or zero-extends it to XLEN.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] buf_data,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    // Replicate the top bit of the selected width unless zero-extending.
    always_comb begin
        result = buf_data;
        case (size)
            SIZE_B:  result = {{(XLEN-8){~is_unsigned & buf_data[7]}}, buf_data[7:0]};
            SIZE_H:  result = {{(XLEN-16){~is_unsigned & buf_data[15]}}, buf_data[15:0]};
            default: result = buf_data;
        endcase
    end

endmodule

// File: rtl/byte_mem_master.sv
// Byte-serial load/store access unit in front of a byte-wide RAM with
// combinational read and clocked write. One byte per cycle, little-endian.
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned half/word
// requests with resp_err instead of walking them bytewise.
module byte_mem_master
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int XLEN      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    byte_mem_master_if.master     bus,
    output state_e                dbg_state
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] ext_data;
`ifdef MISALIGN_CHECK_EN
    logic            err_q, err_d;
    logic            misaligned;
`endif

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .buf_data    (buf_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

`ifdef MISALIGN_CHECK_EN
    // Half needs addr[0]==0, word (and size 3) needs addr[1:0]==0.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = bus.req_addr[0];
            default: misaligned = (bus.req_addr[1:0] != 2'b00);
        endcase
    end
`endif

    // Next-state logic: latch request on accept, walk bytes, then respond.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
`ifdef MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr[AW-1:0];
                    wdata_d = bus.req_wdata;
                    cnt_d   = 2'd0;
                    buf_d   = '0;
                    state_d = ST_BUSY;
`ifdef MISALIGN_CHECK_EN
                    err_d   = misaligned;
                    if (misaligned) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (!write_q) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
                end
                cnt_d = cnt_q + 2'd1;
                if ({1'b0, cnt_q} == byte_count(size_q) - 3'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
`ifdef MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
`ifdef MISALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs from registered state; the write enable is also gated by reset
    // so no byte is written on the edge that resets an in-flight store.
    always_comb begin
        bus.req_ready    = (state_q == ST_IDLE);
        bus.mem_write_en = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = 8'h00;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.resp_err     = 1'b0;
        if (state_q == ST_BUSY) begin
            bus.mem_write_en = write_q & ~reset;
            bus.mem_addr     = addr_q + AW'(cnt_q);
            bus.mem_wdata    = write_q ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
        end
        if (state_q == ST_RESP) begin
            bus.resp_valid = 1'b1;
`ifdef MISALIGN_CHECK_EN
            bus.resp_err   = err_q;
            bus.resp_rdata = (write_q || err_q) ? '0 : ext_data;
`else
            bus.resp_rdata = write_q ? '0 : ext_data;
`endif
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_byte_mem_master.sv
// Directed testbench for byte_mem_master with a behavioural byte RAM.
// Honours MISALIGN_CHECK_EN for the alignment-dependent scenarios.
module tb_byte_mem_master;
    import mem_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int XLEN      = 32;
    localparam int AW        = 10;

    int checks   = 0;
    int failures = 0;

    logic clock = 1'b0;
    logic reset;
    state_e dbg_state;

    byte_mem_master_if #(.XLEN(XLEN), .AW(AW)) bus ();

    byte_mem_master #(.MEM_DEPTH(MEM_DEPTH), .XLEN(XLEN)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clock = ~clock;

    // Byte RAM: combinational read, clocked write; bench preload port.
    logic [7:0]    ram [MEM_DEPTH];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [7:0]    pre_data;
    int            wr_count = 0;

    always @(posedge clock) begin
        if (bus.mem_write_en) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
    end

    assign bus.mem_rdata = ram[bus.mem_addr];

    // Driver tasks.
    task automatic poke(input int addr, input logic [7:0] data);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = AW'(addr);
        pre_data = data;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    // Presents a request so it is accepted at the next rising edge (edge 0),
    // then returns just after that edge, i.e. at the start of cycle 1.
    task automatic start_req(input logic w, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        bus.req_write    = w;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid    = 1'b0;
    endtask

    // Bounded wait for the response pulse; lat = cycle index, 0 on timeout.
    task automatic wait_resp(output int lat, output logic [31:0] rdata, output logic err);
        lat   = 0;
        rdata = 32'hxxxx_xxxx;
        err   = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (bus.resp_valid === 1'b1) begin
                lat   = c;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.mem_write_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: we=%b resp_valid=%b required 0 0", bus.mem_write_en, bus.resp_valid);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_write_en} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl: ready/rv/err/we=%b required 1000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_write_en});
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.mem_addr !== '0 || bus.mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0 0 0",
                     bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_store_word;
        logic [31:0] w;
        w = 32'hDEADBEEF;
        start_req(1'b1, SIZE_W, 1'b0, 32'h10, w);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== AW'(16 + c) ||
                bus.mem_wdata !== w[8*c +: 8] || bus.resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL store_cycle%0d: we=%b addr=%h wdata=%h rv=%b required 1 %h %h 0",
                         c + 1, bus.mem_write_en, bus.mem_addr, bus.mem_wdata, bus.resp_valid,
                         AW'(16 + c), w[8*c +: 8]);
            end
        end
        @(negedge clock);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL store_resp: rv=%b rdata=%h we=%b required 1 0 0",
                     bus.resp_valid, bus.resp_rdata, bus.mem_write_en);
        end
        checks++;
        if ({ram[19], ram[18], ram[17], ram[16]} !== w) begin
            failures++;
            $display("FAIL store_ram: got %h required %h", {ram[19], ram[18], ram[17], ram[16]}, w);
        end
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL store_idle: ready=%b rv=%b required 1 0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_load_byte;
        int lat;
        logic [31:0] rd;
        logic err;
        poke(32'h20, 8'h80);
        start_req(1'b0, SIZE_B, 1'b0, 32'h20, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 2 || rd !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL load_byte_signed: lat=%0d rdata=%h required 2 ffffff80", lat, rd);
        end
        start_req(1'b0, SIZE_B, 1'b1, 32'h20, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 2 || rd !== 32'h00000080) begin
            failures++;
            $display("FAIL load_byte_unsigned: lat=%0d rdata=%h required 2 00000080", lat, rd);
        end
    endtask

    task automatic test_load_half;
        int lat;
        logic [31:0] rd;
        logic err;
        poke(32'h30, 8'h01);
        poke(32'h31, 8'h80);
        start_req(1'b0, SIZE_H, 1'b0, 32'h30, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 3 || rd !== 32'hFFFF8001 || err !== 1'b0) begin
            failures++;
            $display("FAIL load_half_signed: lat=%0d rdata=%h err=%b required 3 ffff8001 0", lat, rd, err);
        end
        start_req(1'b0, SIZE_H, 1'b1, 32'h30, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 3 || rd !== 32'h00008001) begin
            failures++;
            $display("FAIL load_half_unsigned: lat=%0d rdata=%h required 3 00008001", lat, rd);
        end
    endtask

    task automatic test_wrap;
        int lat;
        logic [31:0] rd;
        logic err;
        poke(MEM_DEPTH - 2, 8'h11);
        poke(MEM_DEPTH - 1, 8'h22);
        poke(0, 8'h33);
        poke(1, 8'h44);
`ifdef MISALIGN_CHECK_EN
        start_req(1'b0, SIZE_W, 1'b0, 32'(MEM_DEPTH - 2), 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL wrap_rejected: lat=%0d err=%b rdata=%h required 1 1 0", lat, err, rd);
        end
`else
        start_req(1'b0, SIZE_W, 1'b0, 32'(MEM_DEPTH - 2), 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (bus.mem_addr !== AW'((MEM_DEPTH - 2 + c) % MEM_DEPTH) || bus.mem_write_en !== 1'b0) begin
                failures++;
                $display("FAIL wrap_addr%0d: addr=%h we=%b required %h 0", c, bus.mem_addr,
                         bus.mem_write_en, AW'((MEM_DEPTH - 2 + c) % MEM_DEPTH));
            end
        end
        @(negedge clock);
        lat = 0;
        rd  = bus.resp_rdata;
        checks++;
        if (bus.resp_valid !== 1'b1 || rd !== 32'h44332211 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_data: rv=%b rdata=%h err=%b required 1 44332211 0",
                     bus.resp_valid, rd, bus.resp_err);
        end
`endif
    endtask

    task automatic test_misalign;
        int lat;
        int wr_before;
        logic [31:0] rd;
        logic err;
        poke(32'h21, 8'h01);
        poke(32'h22, 8'h34);
        poke(32'h23, 8'h12);
        poke(32'h24, 8'h84);
`ifdef MISALIGN_CHECK_EN
        start_req(1'b0, SIZE_W, 1'b0, 32'h21, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL misalign_word_load: lat=%0d err=%b rdata=%h required 1 1 0", lat, err, rd);
        end
        wr_before = wr_count;
        start_req(1'b1, 2'd3, 1'b0, 32'h21, 32'hCAFEF00D);
        wait_resp(lat, rd, err);
        @(negedge clock);
        checks++;
        if (lat !== 1 || err !== 1'b1 || wr_count !== wr_before || ram[8'h21] !== 8'h01) begin
            failures++;
            $display("FAIL misalign_store: lat=%0d err=%b writes=%0d ram21=%h required 1 1 0 01",
                     lat, err, wr_count - wr_before, ram[8'h21]);
        end
        start_req(1'b0, SIZE_H, 1'b0, 32'h22, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'h00001234) begin
            failures++;
            $display("FAIL aligned_half: lat=%0d err=%b rdata=%h required 3 0 00001234", lat, err, rd);
        end
`else
        wr_before = wr_count;
        start_req(1'b0, SIZE_W, 1'b0, 32'h21, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 5 || err !== 1'b0 || rd !== 32'h84123401 || wr_count !== wr_before) begin
            failures++;
            $display("FAIL unaligned_word: lat=%0d err=%b rdata=%h writes=%0d required 5 0 84123401 0",
                     lat, err, rd, wr_count - wr_before);
        end
        start_req(1'b0, SIZE_H, 1'b0, 32'h23, 32'h0);
        wait_resp(lat, rd, err);
        checks++;
        if (lat !== 3 || rd !== 32'hFFFF8412) begin
            failures++;
            $display("FAIL unaligned_half: lat=%0d rdata=%h required 3 ffff8412", lat, rd);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int resp_seen;
        resp_seen = 0;
        for (int i = 0; i < 4; i++) poke(32'h40 + i, 8'h00);
        start_req(1'b1, SIZE_W, 1'b0, 32'h40, 32'hA1B2C3D4);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_we: we=%b required 0", bus.mem_write_en);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_mid_idle: ready=%b state=%0d required 1 %0d", bus.req_ready, dbg_state, ST_IDLE);
        end
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid === 1'b1) resp_seen++;
            @(negedge clock);
        end
        checks++;
        if (resp_seen != 0) begin
            failures++;
            $display("FAIL reset_mid_resp: pulses=%0d required 0", resp_seen);
        end
        checks++;
        if ({ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]} !== 32'h000000D4) begin
            failures++;
            $display("FAIL reset_mid_ram: got %h required 000000d4",
                     {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]});
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] ready_bits;
        logic [10:0] resp_bits;
        int bad_data;
        ready_bits = '0;
        resp_bits  = '0;
        bad_data   = 0;
        poke(32'h50, 8'h5A);
        @(negedge clock);
        bus.req_write    = 1'b0;
        bus.req_size     = SIZE_B;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h50;
        bus.req_wdata    = 32'h0;
        bus.req_valid    = 1'b1;
        ready_bits[0]    = bus.req_ready;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            ready_bits[c] = bus.req_ready;
            resp_bits[c]  = bus.resp_valid;
            if (bus.resp_valid === 1'b1 && bus.resp_rdata !== 32'h5A) bad_data++;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 4; c <= 10; c++) begin
            @(negedge clock);
            ready_bits[c] = bus.req_ready;
            resp_bits[c]  = bus.resp_valid;
            if (bus.resp_valid === 1'b1 && bus.resp_rdata !== 32'h5A) bad_data++;
        end
        checks++;
        if (ready_bits[3:0] !== 4'b1001) begin
            failures++;
            $display("FAIL b2b_ready: cycles3..0=%b required 1001", ready_bits[3:0]);
        end
        checks++;
        if (resp_bits !== 11'b000_0010_0100) begin
            failures++;
            $display("FAIL b2b_resp: cycles10..0=%b required 00000100100", resp_bits);
        end
        checks++;
        if (bad_data != 0) begin
            failures++;
            $display("FAIL b2b_data: bad=%0d required 0", bad_data);
        end
    endtask

    initial begin
        reset            = 1'b1;
        pre_we           = 1'b0;
        pre_addr         = '0;
        pre_data         = 8'h00;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
